eth_rx_slot_ctrl: RTL and testbench

- Receive-side buffer manager for the Ethernet MAC.
- Takes the MAC's byte stream and writes it through the 16-bit port A of the dual-port widening frame RAM (13-bit halfword address, 2-bit byte write enable).
- The RAM is divided into a ring of fixed-size frame slots. The block tracks committed frames, their lengths and slot ownership; the CPU reads frames through the 64-bit port and releases each slot when done.

---
 rtl/eth_rx_slot_ctrl.sv | 101 ++++++++++
 tb/tb_eth_rx_slot_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_slot_ctrl.sv
// eth_rx_slot_ctrl: receive byte stream into a ring of frame slots in port A of the frame RAM, track committed frames for the CPU
module eth_rx_slot_ctrl #(
  parameter int SLOT_BITS    = 3,
  parameter int SLOT_HW_BITS = 10,
  parameter int LEN_W        = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  input  logic                            rx_last,
  input  logic                            rx_err,
  input  logic                            slot_release,
  output logic                            mem_ena,
  output logic [1:0]                      mem_wea,
  output logic [SLOT_BITS+SLOT_HW_BITS-1:0] mem_addra,
  output logic [15:0]                     mem_dina,
  output logic [SLOT_BITS-1:0]            head,
  output logic [SLOT_BITS-1:0]            tail,
  output logic [SLOT_BITS:0]              avail,
  output logic [LEN_W-1:0]                first_len,
  output logic                            rx_irq,
  output logic [15:0]                     drop_cnt
);
  localparam int NB = SLOT_HW_BITS + 1;
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t state, state_nxt;
  logic [NB:0] n, n_nxt, n_inc;
  logic [LEN_W-1:0] len [2**SLOT_BITS];
  logic wr, commit, drop, full, rel_ok;
  assign full = avail[SLOT_BITS];
  assign rel_ok = slot_release && avail != '0;
  assign n_inc = n + 1'b1;
  assign rx_irq = avail != '0;
  assign first_len = rx_irq ? len[tail] : '0;
  always_comb begin
    state_nxt = state;
    n_nxt = n;
    wr = 1'b0;
    commit = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        if (full) begin
          drop = 1'b1;
          state_nxt = rx_last ? IDLE : DROP;
        end else begin
          wr = 1'b1;
          commit = rx_last && !rx_err;
          drop = rx_last && rx_err;
          state_nxt = rx_last ? IDLE : RECV;
          n_nxt = rx_last ? '0 : n_inc;
        end
      end
      RECV: if (rx_valid) begin
        // n[NB] set means the slot is already full: this byte overflows it
        if (n[NB]) begin
          drop = 1'b1;
          state_nxt = rx_last ? IDLE : DROP;
          n_nxt = '0;
        end else begin
          wr = 1'b1;
          commit = rx_last && !rx_err;
          drop = rx_last && rx_err;
          state_nxt = rx_last ? IDLE : RECV;
          n_nxt = rx_last ? '0 : n_inc;
        end
      end
      default: if (rx_valid && rx_last) state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n <= '0;
      head <= '0;
      tail <= '0;
      avail <= '0;
      drop_cnt <= '0;
      mem_ena <= 1'b0;
      mem_wea <= '0;
      mem_addra <= '0;
      mem_dina <= '0;
      for (int i = 0; i < 2**SLOT_BITS; i++) len[i] <= '0;
    end else begin
      state <= state_nxt;
      n <= n_nxt;
      head <= head + SLOT_BITS'(commit);
      tail <= tail + SLOT_BITS'(rel_ok);
      avail <= avail + (SLOT_BITS+1)'(commit) - (SLOT_BITS+1)'(rel_ok);
      drop_cnt <= drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
      if (commit) len[head] <= n_inc[LEN_W-1:0];
      mem_ena <= wr;
      mem_wea <= wr ? (n[0] ? 2'b10 : 2'b01) : 2'b00;
      if (wr) begin
        mem_addra <= {head, n[NB-1:1]};
        mem_dina <= {rx_data, rx_data};
      end
    end
  end
endmodule

// File: tb/tb_eth_rx_slot_ctrl.sv
// tb_eth_rx_slot_ctrl: directed frames against hand-computed slot, length and RAM write expectations
module tb_eth_rx_slot_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_last = 1'b0, rx_err = 1'b0, slot_release = 1'b0;
  logic mem_ena;
  logic [1:0] mem_wea;
  logic [12:0] mem_addra;
  logic [15:0] mem_dina, drop_cnt;
  logic [2:0] head, tail;
  logic [3:0] avail;
  logic [10:0] first_len;
  logic rx_irq;
  int n_tests = 0, n_fail = 0;
  logic [12:0] wq_addr [$];
  logic [1:0] wq_wea [$];
  logic [15:0] wq_din [$];

  eth_rx_slot_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .rx_err(rx_err), .slot_release(slot_release), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_dina(mem_dina), .head(head), .tail(tail), .avail(avail),
    .first_len(first_len), .rx_irq(rx_irq), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_ena) begin
    wq_addr.push_back(mem_addra);
    wq_wea.push_back(mem_wea);
    wq_din.push_back(mem_dina);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_wea.delete();
    wq_din.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_last = 1'b0;
    rx_err = 1'b0;
    slot_release = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic put(input logic [7:0] d, input bit last, input bit err);
    rx_data = d;
    rx_valid = 1'b1;
    rx_last = last;
    rx_err = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_last = 1'b0;
    rx_err = 1'b0;
  endtask

  task automatic frame(input int len, input bit err);
    for (int i = 0; i < len; i++) put(8'(i + 1), i == len - 1, err && i == len - 1);
    @(negedge clk);
  endtask

  task automatic pulse_release();
    slot_release = 1'b1;
    @(negedge clk);
    slot_release = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_head", head, 0);
    chk("rst_tail", tail, 0);
    chk("rst_avail", avail, 0);
    chk("rst_first_len", first_len, 0);
    chk("rst_irq", rx_irq, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ena", mem_ena, 0);
    chk("rst_wea", mem_wea, 0);
    chk("rst_addr", mem_addra, 0);
    chk("rst_din", mem_dina, 0);

    put(8'hA1, 0, 0);
    put(8'hB2, 0, 0);
    put(8'hC3, 1, 0);
    @(negedge clk);
    chk("f3_nwr", wq_addr.size(), 3);
    chk("f3_a0", {wq_addr[0], wq_wea[0], wq_din[0]}, {13'h0000, 2'b01, 16'hA1A1});
    chk("f3_a1", {wq_addr[1], wq_wea[1], wq_din[1]}, {13'h0000, 2'b10, 16'hB2B2});
    chk("f3_a2", {wq_addr[2], wq_wea[2], wq_din[2]}, {13'h0001, 2'b01, 16'hC3C3});
    chk("f3_head", head, 1);
    chk("f3_avail", avail, 1);
    chk("f3_len", first_len, 3);
    chk("f3_irq", rx_irq, 1);
    chk("f3_idle_ena", mem_ena, 0);

    do_reset();
    for (int f = 0; f < 8; f++) frame(64, 0);
    chk("full_avail", avail, 8);
    chk("full_head", head, 0);
    clear_log();
    frame(64, 0);
    chk("full_nwr", wq_addr.size(), 0);
    chk("full_drop", drop_cnt, 1);
    chk("full_avail2", avail, 8);
    chk("full_head2", head, 0);
    chk("full_tail", tail, 0);
    chk("full_len", first_len, 64);
    pulse_release();
    chk("rel_tail", tail, 1);
    chk("rel_avail", avail, 7);

    do_reset();
    frame(2049, 0);
    chk("ovf_nwr", wq_addr.size(), 2048);
    chk("ovf_last", {wq_addr[2047], wq_wea[2047]}, {13'h03FF, 2'b10});
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_avail", avail, 0);
    chk("ovf_head", head, 0);
    clear_log();
    frame(60, 0);
    chk("ovf_next_a0", {wq_addr[0], wq_wea[0]}, {13'h0000, 2'b01});
    chk("ovf_next_len", first_len, 60);
    chk("ovf_next_head", head, 1);

    do_reset();
    frame(2048, 0);
    chk("max_nwr", wq_addr.size(), 2048);
    chk("max_last", {wq_addr[2047], wq_wea[2047]}, {13'h03FF, 2'b10});
    chk("max_avail", avail, 1);
    chk("max_len", first_len, 0);
    chk("max_irq", rx_irq, 1);
    chk("max_drop", drop_cnt, 0);

    do_reset();
    frame(100, 1);
    chk("err_avail", avail, 0);
    chk("err_head", head, 0);
    chk("err_drop", drop_cnt, 1);
    chk("err_irq", rx_irq, 0);
    clear_log();
    frame(1, 0);
    chk("one_nwr", wq_addr.size(), 1);
    chk("one_a0", {wq_addr[0], wq_wea[0]}, {13'h0000, 2'b01});
    chk("one_avail", avail, 1);
    chk("one_len", first_len, 1);
    pulse_release();
    chk("rel_empty_len", first_len, 0);
    pulse_release();
    chk("rel_empty_avail", avail, 0);
    chk("rel_empty_tail", tail, 1);

    do_reset();
    frame(5, 0);
    frame(6, 0);
    frame(7, 0);
    chk("cr_avail0", avail, 3);
    chk("cr_len0", first_len, 5);
    for (int i = 0; i < 8; i++) put(8'(i), 0, 0);
    slot_release = 1'b1;
    put(8'h99, 1, 0);
    slot_release = 1'b0;
    @(negedge clk);
    chk("cr_avail", avail, 3);
    chk("cr_head", head, 4);
    chk("cr_tail", tail, 1);
    chk("cr_len", first_len, 6);

    for (int i = 0; i < 10; i++) put(8'(i), 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_head", head, 0);
    chk("mid_tail", tail, 0);
    chk("mid_avail", avail, 0);
    chk("mid_len", first_len, 0);
    chk("mid_irq", rx_irq, 0);
    chk("mid_drop", drop_cnt, 0);
    chk("mid_ena", {mem_ena, mem_wea, mem_addra, mem_dina}, 0);
    rst = 1'b0;
    clear_log();
    frame(2, 0);
    chk("mid_nwr", wq_addr.size(), 2);
    chk("mid_a0", {wq_addr[0], wq_wea[0]}, {13'h0000, 2'b01});
    chk("mid_a1", {wq_addr[1], wq_wea[1]}, {13'h0000, 2'b10});
    chk("mid_next_len", first_len, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
